// File: rtl/open_loop_pkg.sv
// Shared types for the open-loop benchmark application.
//   flag_e : one-bit boolean flag carried by datapath status signals.
package open_loop_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } flag_e;

endpackage

// File: rtl/tx_open_loop_pkg.sv
// Types for the open-loop TX engine.
//   tx_out_mux_sel_e : selects which NoC flit the datapath drives out.
//   tx_ctrl_state_e  : states of the TX engine control FSM.
package tx_open_loop_pkg;

    typedef enum logic {
        MSG_REQ    = 1'b0,
        PTR_UPDATE = 1'b1
    } tx_out_mux_sel_e;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RD_STATE   = 4'd1,
        WAIT_STATE = 4'd2,
        REQ_SPACE  = 4'd3,
        WAIT_NOTIF = 4'd4,
        WR_HDR     = 4'd5,
        WR_DATA    = 4'd6,
        PTR_UPD    = 4'd7,
        WR_STATE   = 4'd8,
        REENQ      = 4'd9
    } tx_ctrl_state_e;

endpackage

// File: rtl/open_loop_tx_engine_ctrl.sv
// Control FSM for the open-loop benchmark TX engine. One send-queue entry is
// processed at a time: dequeue, read the flow context, request TX buffer space,
// wait for the tail-pointer notification, optionally copy the payload, post the
// pointer adjust, write the context back, then re-enqueue the flow unless it
// just sent its last packet.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   send_q_*                   send-queue dequeue strobe / re-enqueue handshake
//   tx_app_state_*             flow context read request/response and write
//   tx_app_noc_vrtoc_*         MSG_REQ flit to TCP TX
//   ctrl_noc_tx_ptr_if_*       tail-pointer notification from TCP TX
//   tx_ptr_if_ctrl_noc_*       ADJUST_PTR flit to TCP TX
//   datap_wr_buf_req_*         TX buffer write header / data beats
//   ctrl_datap_*               datapath load strobes and output mux select
//   datap_ctrl_*               datapath status flags
//   app_done                   one-cycle pulse when a flow finishes
//   stall_cnt                  cycles spent waiting on the notification
//                              (only when OPEN_LOOP_TX_STALL_CNT_EN is defined)
//
// Build option: define OPEN_LOOP_TX_STALL_CNT_EN to add the saturating
// notification stall counter and its stall_cnt output.
module open_loop_tx_engine_ctrl
    import open_loop_pkg::*;
    import tx_open_loop_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            send_q_rd_val,
    output logic            send_q_rd_req,
    output logic            send_q_wr_val,
    input  logic            send_q_wr_rdy,

    output logic            tx_app_state_rd_req_val,
    input  logic            tx_app_state_rd_req_rdy,
    input  logic            app_state_tx_rd_resp_val,
    output logic            tx_app_state_rd_resp_rdy,
    output logic            tx_app_state_wr_val,
    input  logic            tx_app_state_wr_rdy,

    output logic            tx_app_noc_vrtoc_val,
    input  logic            noc_vrtoc_tx_app_rdy,
    input  logic            ctrl_noc_tx_ptr_if_val,
    output logic            tx_ptr_if_ctrl_noc_rdy,
    output logic            tx_ptr_if_ctrl_noc_val,
    input  logic            ctrl_noc_tx_ptr_if_rdy,

    output logic            datap_wr_buf_req_val,
    input  logic            wr_buf_datap_req_rdy,
    output logic            datap_wr_buf_req_data_val,
    input  logic            wr_buf_datap_req_data_rdy,

    output logic            ctrl_datap_store_inputs,
    output logic            ctrl_datap_store_app_state,
    output logic            ctrl_datap_decr_bytes_left,
    output logic            ctrl_datap_store_notif,
    output tx_out_mux_sel_e ctrl_datap_out_mux_sel,

    input  logic            datap_ctrl_last_wr,
    input  logic            datap_ctrl_last_pkt,
    input  flag_e           datap_ctrl_should_copy,

    output logic            app_done
`ifdef OPEN_LOOP_TX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (STALL_CNT_W < 2) begin : g_bad_stall_cnt_w
        $error("STALL_CNT_W must be at least 2");
    end

    tx_ctrl_state_e state;
    tx_ctrl_state_e state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All outputs are pure state decodes gated by the matching handshake input,
    // so every val holds steady until its rdy arrives.
    always_comb begin
        state_next                 = state;
        send_q_rd_req              = 1'b0;
        send_q_wr_val              = 1'b0;
        tx_app_state_rd_req_val    = 1'b0;
        tx_app_state_rd_resp_rdy   = 1'b0;
        tx_app_state_wr_val        = 1'b0;
        tx_app_noc_vrtoc_val       = 1'b0;
        tx_ptr_if_ctrl_noc_rdy     = 1'b0;
        tx_ptr_if_ctrl_noc_val     = 1'b0;
        datap_wr_buf_req_val       = 1'b0;
        datap_wr_buf_req_data_val  = 1'b0;
        ctrl_datap_store_inputs    = 1'b0;
        ctrl_datap_store_app_state = 1'b0;
        ctrl_datap_decr_bytes_left = 1'b0;
        ctrl_datap_store_notif     = 1'b0;
        ctrl_datap_out_mux_sel     = MSG_REQ;
        app_done                   = 1'b0;

        case (state)
            IDLE: begin
                if (send_q_rd_val) begin
                    send_q_rd_req           = 1'b1;
                    ctrl_datap_store_inputs = 1'b1;
                    state_next              = RD_STATE;
                end
            end
            RD_STATE: begin
                tx_app_state_rd_req_val = 1'b1;
                if (tx_app_state_rd_req_rdy) begin
                    state_next = WAIT_STATE;
                end
            end
            WAIT_STATE: begin
                tx_app_state_rd_resp_rdy = 1'b1;
                if (app_state_tx_rd_resp_val) begin
                    ctrl_datap_store_app_state = 1'b1;
                    state_next                 = REQ_SPACE;
                end
            end
            REQ_SPACE: begin
                ctrl_datap_out_mux_sel = MSG_REQ;
                tx_app_noc_vrtoc_val   = 1'b1;
                if (noc_vrtoc_tx_app_rdy) begin
                    state_next = WAIT_NOTIF;
                end
            end
            WAIT_NOTIF: begin
                tx_ptr_if_ctrl_noc_rdy = 1'b1;
                if (ctrl_noc_tx_ptr_if_val) begin
                    ctrl_datap_store_notif = 1'b1;
                    state_next = (datap_ctrl_should_copy == TRUE) ? WR_HDR : PTR_UPD;
                end
            end
            WR_HDR: begin
                datap_wr_buf_req_val = 1'b1;
                if (wr_buf_datap_req_rdy) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                // last_wr describes the beat being accepted now, so a
                // single-beat payload leaves after its only beat.
                datap_wr_buf_req_data_val = 1'b1;
                if (wr_buf_datap_req_data_rdy) begin
                    ctrl_datap_decr_bytes_left = 1'b1;
                    if (datap_ctrl_last_wr) begin
                        state_next = PTR_UPD;
                    end
                end
            end
            PTR_UPD: begin
                // Posted: the adjust is fire-and-forget, no ack is awaited.
                ctrl_datap_out_mux_sel = PTR_UPDATE;
                tx_ptr_if_ctrl_noc_val = 1'b1;
                if (ctrl_noc_tx_ptr_if_rdy) begin
                    state_next = WR_STATE;
                end
            end
            WR_STATE: begin
                // last_pkt reflects the context as read, before the increment
                // that is being written back.
                tx_app_state_wr_val = 1'b1;
                if (tx_app_state_wr_rdy) begin
                    if (datap_ctrl_last_pkt) begin
                        app_done   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = REENQ;
                    end
                end
            end
            REENQ: begin
                send_q_wr_val = 1'b1;
                if (send_q_wr_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef OPEN_LOOP_TX_STALL_CNT_EN
    // Saturating count of cycles spent waiting for the tail-pointer notification.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == WAIT_NOTIF) && !ctrl_noc_tx_ptr_if_val && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_open_loop_tx_engine_ctrl.sv
// Directed bench for open_loop_tx_engine_ctrl. Responders answer every
// handshake; an optional hold keeps each ready low for a number of cycles
// after the DUT enters a new state.
module tb_open_loop_tx_engine_ctrl;
    import open_loop_pkg::*;
    import tx_open_loop_pkg::*;

    localparam int C_DEQ     = 0;
    localparam int C_APPST   = 1;
    localparam int C_NOTIF   = 2;
    localparam int C_MSG     = 3;
    localparam int C_PTR     = 4;
    localparam int C_HDR     = 5;
    localparam int C_BEAT    = 6;
    localparam int C_DECR    = 7;
    localparam int C_STWR    = 8;
    localparam int C_REENQ   = 9;
    localparam int C_DONE    = 10;
    localparam int C_MUXBAD  = 11;
    localparam int C_OVERLAP = 12;

    logic clk = 1'b0;
    logic rst;
    logic send_q_rd_val, send_q_rd_req, send_q_wr_val, send_q_wr_rdy;
    logic tx_app_state_rd_req_val, tx_app_state_rd_req_rdy;
    logic app_state_tx_rd_resp_val, tx_app_state_rd_resp_rdy;
    logic tx_app_state_wr_val, tx_app_state_wr_rdy;
    logic tx_app_noc_vrtoc_val, noc_vrtoc_tx_app_rdy;
    logic ctrl_noc_tx_ptr_if_val, tx_ptr_if_ctrl_noc_rdy;
    logic tx_ptr_if_ctrl_noc_val, ctrl_noc_tx_ptr_if_rdy;
    logic datap_wr_buf_req_val, wr_buf_datap_req_rdy;
    logic datap_wr_buf_req_data_val, wr_buf_datap_req_data_rdy;
    logic ctrl_datap_store_inputs, ctrl_datap_store_app_state;
    logic ctrl_datap_decr_bytes_left, ctrl_datap_store_notif;
    tx_out_mux_sel_e ctrl_datap_out_mux_sel;
    logic datap_ctrl_last_wr, datap_ctrl_last_pkt;
    flag_e datap_ctrl_should_copy;
    logic app_done;
`ifdef OPEN_LOOP_TX_STALL_CNT_EN
    logic [3:0] stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int stable_bad = 0;
    int cnt [0:12];
    int base [0:12];

    always #5 clk = ~clk;

    open_loop_tx_engine_ctrl #(.STALL_CNT_W(4)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .send_q_rd_val              (send_q_rd_val),
        .send_q_rd_req              (send_q_rd_req),
        .send_q_wr_val              (send_q_wr_val),
        .send_q_wr_rdy              (send_q_wr_rdy),
        .tx_app_state_rd_req_val    (tx_app_state_rd_req_val),
        .tx_app_state_rd_req_rdy    (tx_app_state_rd_req_rdy),
        .app_state_tx_rd_resp_val   (app_state_tx_rd_resp_val),
        .tx_app_state_rd_resp_rdy   (tx_app_state_rd_resp_rdy),
        .tx_app_state_wr_val        (tx_app_state_wr_val),
        .tx_app_state_wr_rdy        (tx_app_state_wr_rdy),
        .tx_app_noc_vrtoc_val       (tx_app_noc_vrtoc_val),
        .noc_vrtoc_tx_app_rdy       (noc_vrtoc_tx_app_rdy),
        .ctrl_noc_tx_ptr_if_val     (ctrl_noc_tx_ptr_if_val),
        .tx_ptr_if_ctrl_noc_rdy     (tx_ptr_if_ctrl_noc_rdy),
        .tx_ptr_if_ctrl_noc_val     (tx_ptr_if_ctrl_noc_val),
        .ctrl_noc_tx_ptr_if_rdy     (ctrl_noc_tx_ptr_if_rdy),
        .datap_wr_buf_req_val       (datap_wr_buf_req_val),
        .wr_buf_datap_req_rdy       (wr_buf_datap_req_rdy),
        .datap_wr_buf_req_data_val  (datap_wr_buf_req_data_val),
        .wr_buf_datap_req_data_rdy  (wr_buf_datap_req_data_rdy),
        .ctrl_datap_store_inputs    (ctrl_datap_store_inputs),
        .ctrl_datap_store_app_state (ctrl_datap_store_app_state),
        .ctrl_datap_decr_bytes_left (ctrl_datap_decr_bytes_left),
        .ctrl_datap_store_notif     (ctrl_datap_store_notif),
        .ctrl_datap_out_mux_sel     (ctrl_datap_out_mux_sel),
        .datap_ctrl_last_wr         (datap_ctrl_last_wr),
        .datap_ctrl_last_pkt        (datap_ctrl_last_pkt),
        .datap_ctrl_should_copy     (datap_ctrl_should_copy),
        .app_done                   (app_done)
`ifdef OPEN_LOOP_TX_STALL_CNT_EN
        ,
        .stall_cnt                  (stall_cnt)
`endif
    );

    // Event counters, sampled mid-cycle for the handshakes of the coming edge.
    initial begin
        for (int i = 0; i <= 12; i++) cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ctrl_datap_store_inputs) cnt[C_DEQ]++;
            if (ctrl_datap_store_app_state) cnt[C_APPST]++;
            if (ctrl_datap_store_notif) cnt[C_NOTIF]++;
            if (tx_app_noc_vrtoc_val && noc_vrtoc_tx_app_rdy) begin
                cnt[C_MSG]++;
                if (ctrl_datap_out_mux_sel != MSG_REQ) cnt[C_MUXBAD]++;
            end
            if (tx_ptr_if_ctrl_noc_val && ctrl_noc_tx_ptr_if_rdy) begin
                cnt[C_PTR]++;
                if (ctrl_datap_out_mux_sel != PTR_UPDATE) cnt[C_MUXBAD]++;
            end
            if (datap_wr_buf_req_val && wr_buf_datap_req_rdy) cnt[C_HDR]++;
            if (datap_wr_buf_req_data_val && wr_buf_datap_req_data_rdy) cnt[C_BEAT]++;
            if (ctrl_datap_decr_bytes_left) cnt[C_DECR]++;
            if (tx_app_state_wr_val && tx_app_state_wr_rdy) cnt[C_STWR]++;
            if (send_q_wr_val && send_q_wr_rdy) cnt[C_REENQ]++;
            if (app_done) begin
                cnt[C_DONE]++;
                if (!(tx_app_state_wr_val && tx_app_state_wr_rdy)) cnt[C_OVERLAP]++;
            end
            if (send_q_rd_req && (cur_sig() != '0)) cnt[C_OVERLAP]++;
        end
    end

    function automatic logic [9:0] cur_sig();
        return {send_q_wr_val, tx_app_state_rd_req_val, tx_app_state_rd_resp_rdy,
                tx_app_noc_vrtoc_val, tx_ptr_if_ctrl_noc_rdy, tx_ptr_if_ctrl_noc_val,
                datap_wr_buf_req_val, datap_wr_buf_req_data_val, tx_app_state_wr_val,
                (ctrl_datap_out_mux_sel == PTR_UPDATE)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i <= 12; i++) base[i] = cnt[i];
    endtask

    function automatic int d(input int k);
        return cnt[k] - base[k];
    endfunction

    task automatic set_rdys(input logic v);
        send_q_wr_rdy             = v;
        tx_app_state_rd_req_rdy   = v;
        app_state_tx_rd_resp_val  = v;
        tx_app_state_wr_rdy       = v;
        noc_vrtoc_tx_app_rdy      = v;
        ctrl_noc_tx_ptr_if_val    = v;
        ctrl_noc_tx_ptr_if_rdy    = v;
        wr_buf_datap_req_rdy      = v;
        wr_buf_datap_req_data_rdy = v;
    endtask

    // Process one entry from dequeue to its final handshake. Returns the
    // number of cycles from the dequeue cycle to the final handshake inclusive.
    task automatic run_entry(input flag_e copy, input int nbeats, input logic lastp,
                             input int hold, input bit keep, output int cycles);
        int beats, wait_ctr;
        logic [9:0] sig, psig;
        bit started, held_prev, done;
        beats = 0; wait_ctr = 0; psig = '0; started = 0; held_prev = 0; done = 0;
        cycles = 0;
        datap_ctrl_should_copy = copy;
        datap_ctrl_last_pkt    = lastp;
        send_q_rd_val          = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            sig = cur_sig();
            if (held_prev && sig !== psig) stable_bad++;
            if (sig !== psig) wait_ctr = 0;
            psig = sig;
            set_rdys(wait_ctr >= hold);
            held_prev = (hold > 0) && (wait_ctr < hold) && (sig != '0);
            datap_ctrl_last_wr = (nbeats > 0) && (beats == nbeats - 1);
            @(negedge clk);
            if (send_q_rd_req) started = 1;
            if (started) cycles++;
            if (datap_wr_buf_req_data_val && wr_buf_datap_req_data_rdy) beats++;
            if (started && (lastp ? (tx_app_state_wr_val && tx_app_state_wr_rdy)
                                  : (send_q_wr_val && send_q_wr_rdy))) done = 1;
            tick();
            if (started && !keep) send_q_rd_val = 1'b0;
            wait_ctr++;
        end
        send_q_rd_val      = 1'b0;
        datap_ctrl_last_wr = 1'b0;
        chk("entry_completes", int'(done), 1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        send_q_rd_val = 1'b0;
        set_rdys(1'b0);
        datap_ctrl_last_wr = 1'b0;
        datap_ctrl_last_pkt = 1'b0;
        datap_ctrl_should_copy = FALSE;
        repeat (3) tick();

        // Reset state
        chk("rst_vals", int'(cur_sig()), 0);
        chk("rst_mux", int'(ctrl_datap_out_mux_sel), int'(MSG_REQ));
        chk("rst_app_done", int'(app_done), 0);
        chk("rst_strobes", int'({ctrl_datap_store_inputs, ctrl_datap_store_app_state,
                                 ctrl_datap_decr_bytes_left, ctrl_datap_store_notif}), 0);
        chk("rst_rd_req", int'(send_q_rd_req), 0);
        rst = 1'b0;
        set_rdys(1'b1);
        tick();

        // No copy, not last packet
        snap();
        run_entry(FALSE, 0, 1'b0, 0, 1'b0, cyc);
        chk("nocopy_cycles", cyc, 8);
        chk("nocopy_msg", d(C_MSG), 1);
        chk("nocopy_ptr", d(C_PTR), 1);
        chk("nocopy_hdr", d(C_HDR), 0);
        chk("nocopy_beats", d(C_BEAT), 0);
        chk("nocopy_stwr", d(C_STWR), 1);
        chk("nocopy_reenq", d(C_REENQ), 1);
        chk("nocopy_done", d(C_DONE), 0);

        // 64B copy: two beats; queue head kept valid through the re-enqueue
        snap();
        run_entry(TRUE, 2, 1'b0, 0, 1'b1, cyc);
        chk("copy64_cycles", cyc, 11);
        chk("copy64_hdr", d(C_HDR), 1);
        chk("copy64_beats", d(C_BEAT), 2);
        chk("copy64_decr", d(C_DECR), 2);
        chk("copy64_ptr", d(C_PTR), 1);
        chk("copy64_reenq", d(C_REENQ), 1);
        chk("copy64_deq", d(C_DEQ), 1);

        // 20B copy: one beat
        snap();
        run_entry(TRUE, 1, 1'b0, 0, 1'b0, cyc);
        chk("copy20_cycles", cyc, 10);
        chk("copy20_beats", d(C_BEAT), 1);
        chk("copy20_decr", d(C_DECR), 1);

        // Last packet: app_done, no re-enqueue
        snap();
        run_entry(FALSE, 0, 1'b1, 0, 1'b0, cyc);
        chk("last_cycles", cyc, 7);
        chk("last_stwr", d(C_STWR), 1);
        chk("last_done", d(C_DONE), 1);
        chk("last_reenq", d(C_REENQ), 0);
        tick();
        chk("last_idle_vals", int'(cur_sig()), 0);
        chk("last_done_low", int'(app_done), 0);

        // Every ready held low 5 cycles in each state
        snap();
        run_entry(TRUE, 2, 1'b0, 5, 1'b0, cyc);
        chk("hold_cycles", cyc, 56);
        chk("hold_deq", d(C_DEQ), 1);
        chk("hold_appst", d(C_APPST), 1);
        chk("hold_notif", d(C_NOTIF), 1);
        chk("hold_msg", d(C_MSG), 1);
        chk("hold_ptr", d(C_PTR), 1);
        chk("hold_beats", d(C_BEAT), 2);
        chk("hold_decr", d(C_DECR), 2);
        chk("hold_stwr", d(C_STWR), 1);
        chk("hold_reenq", d(C_REENQ), 1);
        chk("hold_stable", stable_bad, 0);

        // Reset during WR_DATA after 1 of 4 beats
        snap();
        set_rdys(1'b1);
        datap_ctrl_should_copy = TRUE;
        datap_ctrl_last_pkt = 1'b0;
        datap_ctrl_last_wr = 1'b0;
        send_q_rd_val = 1'b1;
        tick();
        send_q_rd_val = 1'b0;
        repeat (6) tick();
        chk("abort_in_wr_data", int'(datap_wr_buf_req_data_val), 1);
        chk("abort_beats_before", d(C_BEAT), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vals", int'(cur_sig()), 0);
        chk("abort_app_done", int'(app_done), 0);
        repeat (2) tick();
        chk("abort_idle_vals", int'(cur_sig()), 0);
        chk("abort_no_stwr", d(C_STWR), 0);
        chk("abort_no_reenq", d(C_REENQ), 0);

        // Normal entry after the abort
        snap();
        run_entry(TRUE, 2, 1'b0, 0, 1'b0, cyc);
        chk("post_abort_cycles", cyc, 11);
        chk("post_abort_beats", d(C_BEAT), 2);
        chk("post_abort_reenq", d(C_REENQ), 1);

        chk("mux_at_handshakes", cnt[C_MUXBAD], 0);
        chk("no_overlap", cnt[C_OVERLAP], 0);

`ifdef OPEN_LOOP_TX_STALL_CNT_EN
        // Stall counter: 4 bits wide here, so all-ones is 15
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stall_rst", int'(stall_cnt), 0);
        run_entry(FALSE, 0, 1'b0, 7, 1'b0, cyc);
        chk("stall_hold7_cycles", cyc, 57);
        chk("stall_7", int'(stall_cnt), 7);
        run_entry(FALSE, 0, 1'b0, 9, 1'b0, cyc);
        chk("stall_sat", int'(stall_cnt), 15);
        run_entry(FALSE, 0, 1'b0, 3, 1'b0, cyc);
        chk("stall_stays_sat", int'(stall_cnt), 15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
